spi_slave_bfm: RTL and testbench



---
 rtl/spi_slave_bfm.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_bfm.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bfm.sv
// spi_slave_bfm: SPI slave endpoint with all bus pins oversampled on pclk.
// Full-duplex words move between the SPI pins and a valid/ready user port.
module spi_slave_bfm #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;

  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] word_load;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  miso_q;

  logic sclk_rise, sclk_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  logic word_start, word_done;
  logic do_sample, do_shift, abort;

  function automatic logic head(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(
    input logic [DATA_WIDTH-1:0] w
  );
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0}
                     : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s[1] & cs_s[2];
  assign cs_rise     = cs_s[1] & ~cs_s[2];

  assign rx_next = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_s[1]}
                             : {mosi_s[1], rx_sr[DATA_WIDTH-1:1]};
  assign word_load = hold_full ? hold_data : '0;

  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    word_done  = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          do_sample  = sample_edge;
          // CPHA=0 already shows the first bit at word start
          do_shift   = shift_edge && (CPHA || bit_cnt != '0);
          word_done  = sample_edge && bit_cnt == LAST;
          word_start = word_done;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      sclk_s      <= {3{CPOL}};
      // low so a select held across reset never looks like a fresh fall
      cs_s        <= '0;
      mosi_s      <= '0;
      state_q     <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
    end else begin
      sclk_s      <= {sclk_s[1:0], sclk};
      cs_s        <= {cs_s[1:0], cs_n};
      mosi_s      <= {mosi_s[0], mosi};
      state_q     <= state_d;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (abort) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end
      if (do_sample) begin
        rx_sr   <= rx_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end
      if (word_start) begin
        tx_underrun <= ~hold_full;
        if (!CPHA) begin
          miso_q <= head(word_load);
          tx_sr  <= advance(word_load);
        end else begin
          tx_sr <= word_load;
        end
      end else if (do_shift) begin
        miso_q <= head(tx_sr);
        tx_sr  <= advance(tx_sr);
      end
      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end else if (word_start) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign busy     = (state_q == SHIFT);
  assign miso_en  = busy;
  assign miso     = miso_en & miso_q;
  assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_bfm.sv
// tb_spi_slave_bfm: SPI master model driving three slave variants
// (mode 0 MSB, mode 3 MSB, mode 0 LSB) with a queue-based scoreboard.
module tb_spi_slave_bfm;

  logic pclk = 1'b0;
  logic areset;
  logic sclk;
  logic mosi;
  logic [7:0] tx_data;

  logic cs_n [3];
  logic tx_valid [3];
  logic miso [3];
  logic miso_en [3];
  logic tx_ready [3];
  logic rx_valid [3];
  logic tx_underrun [3];
  logic busy [3];
  logic [7:0] rx_data [3];

  int rx_cnt [3];
  int un_cnt [3];
  logic [7:0] last_rx [3];

  logic [7:0] exp_rx [$];
  logic [7:0] exp_tx [$];
  logic [7:0] obs_tx [$];

  logic [7:0] m_words [4];
  logic [7:0] t_words [4];
  int sel;
  int checks;
  int errors;

  initial forever #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    spi_slave_bfm #(
      .DATA_WIDTH(8),
      .CPOL(g == 1),
      .CPHA(g == 1),
      .MSB_FIRST(g != 2)
    ) u_dut (
      .pclk(pclk),
      .areset(areset),
      .sclk(sclk),
      .cs_n(cs_n[g]),
      .mosi(mosi),
      .miso(miso[g]),
      .miso_en(miso_en[g]),
      .tx_data(tx_data),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]),
      .rx_valid(rx_valid[g]),
      .tx_underrun(tx_underrun[g]),
      .busy(busy[g])
    );

    always @(negedge pclk) begin
      if (!areset) begin
        if (rx_valid[g]) begin
          rx_cnt[g]++;
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected inst %0d got %0h want none",
                     g, rx_data[g]);
          end else begin
            check("rx_inst", g, sel);
            check("rx_data", rx_data[g], exp_rx.pop_front());
          end
        end
        if (tx_underrun[g]) un_cnt[g]++;
      end
    end
  end

  initial forever begin
    @(negedge pclk);
    while (obs_tx.size() > 0) begin
      logic [7:0] got;
      got = obs_tx.pop_front();
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected got %0h want none", got);
      end else begin
        check("miso_word", got, exp_tx.pop_front());
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input int g);
    check("rst_miso", miso[g], 0);
    check("rst_miso_en", miso_en[g], 0);
    check("rst_rx_data", rx_data[g], 0);
    check("rst_rx_valid", rx_valid[g], 0);
    check("rst_tx_ready", tx_ready[g], 1);
    check("rst_tx_underrun", tx_underrun[g], 0);
    check("rst_busy", busy[g], 0);
  endtask

  task automatic load_tx(input int g, input logic [7:0] d);
    int t = 0;
    while (tx_ready[g] !== 1'b1 && t < 300) begin
      wait_clk(1);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL tx_ready_timeout inst %0d got 0 want 1", g);
    end else begin
      tx_data     = d;
      tx_valid[g] = 1'b1;
      wait_clk(1);
      tx_valid[g] = 1'b0;
    end
  endtask

  task automatic run_frame(input int g, input int n, input int ntx,
                           input int abort_bits);
    bit cpol, cpha, msb, stop;
    int rx0, un0, nbits, started, b;
    logic [7:0] cap;
    cpol = (g == 1);
    cpha = (g == 1);
    msb  = (g != 2);
    sel  = g;
    sclk = cpol;
    mosi = 1'b0;
    wait_clk(4);
    rx0 = rx_cnt[g];
    un0 = un_cnt[g];
    if (abort_bits == 0)
      for (int k = 0; k < n; k++) begin
        exp_rx.push_back(m_words[k]);
        exp_tx.push_back(k < ntx ? t_words[k] : 8'h00);
      end
    if (ntx > 0) load_tx(g, t_words[0]);
    cs_n[g] = 1'b0;
    wait_clk(2);
    check("busy_early", busy[g], 0);
    wait_clk(1);
    check("busy_on", busy[g], 1);
    check("miso_en_on", miso_en[g], 1);
    check("underrun_at_start", tx_underrun[g], ntx == 0);
    if (ntx > 0) check("tx_ready_after_load", tx_ready[g], 1);
    wait_clk(2);
    stop  = 1'b0;
    nbits = 0;
    fork
      for (int k = 1; k < ntx; k++) load_tx(g, t_words[k]);
      begin
        for (int k = 0; k < n && !stop; k++) begin
          cap = '0;
          for (int i = 0; i < 8 && !stop; i++) begin
            b = msb ? 7 - i : i;
            if (!cpha) begin
              mosi = m_words[k][b];
              wait_clk(5);
              cap[b] = miso[g];
              sclk = ~cpol;
              wait_clk(5);
              sclk = cpol;
            end else begin
              sclk = ~cpol;
              mosi = m_words[k][b];
              wait_clk(5);
              cap[b] = miso[g];
              sclk = cpol;
              wait_clk(5);
            end
            nbits++;
            if (abort_bits != 0 && nbits == abort_bits) stop = 1'b1;
          end
          if (!stop) obs_tx.push_back(cap);
        end
      end
    join
    wait_clk(5);
    cs_n[g] = 1'b1;
    wait_clk(2);
    check("busy_hold", busy[g], 1);
    wait_clk(1);
    check("busy_off", busy[g], 0);
    check("miso_en_off", miso_en[g], 0);
    check("miso_off", miso[g], 0);
    wait_clk(4);
    started = (abort_bits != 0) ? abort_bits / 8 + 1 : n + 1;
    check("rx_valid_count", rx_cnt[g] - rx0, (abort_bits != 0) ? 0 : n);
    check("underrun_count", un_cnt[g] - un0, started - ntx);
    if (abort_bits == 0 && n > 0) last_rx[g] = m_words[n-1];
    check("rx_data_hold", rx_data[g], last_rx[g]);
    check("tx_ready_idle", tx_ready[g], 1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    sel     = 0;
    areset  = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = '0;
    for (int g = 0; g < 3; g++) begin
      cs_n[g]     = 1'b1;
      tx_valid[g] = 1'b0;
      rx_cnt[g]   = 0;
      un_cnt[g]   = 0;
      last_rx[g]  = '0;
    end
    wait_clk(3);
    for (int g = 0; g < 3; g++) check_reset(g);
    areset = 1'b0;
    wait_clk(4);

    m_words[0] = 8'h3C; t_words[0] = 8'hA5;
    run_frame(0, 1, 1, 0);

    m_words[0] = 8'hF0; m_words[1] = 8'h0F;
    t_words[0] = 8'h12; t_words[1] = 8'h34;
    run_frame(1, 2, 2, 0);

    m_words[0] = 8'h55;
    run_frame(0, 1, 0, 0);

    m_words[0] = 8'($urandom);
    run_frame(0, 1, 0, 5);
    m_words[0] = 8'h81; t_words[0] = 8'h7E;
    run_frame(0, 1, 1, 0);

    load_tx(0, 8'hC3);
    sel = 0;
    sclk = 1'b0;
    cs_n[0] = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      wait_clk(5); sclk = 1'b1;
      wait_clk(5); sclk = 1'b0;
    end
    areset = 1'b1;
    #1;
    check_reset(0);
    wait_clk(2);
    areset = 1'b0;
    for (int g = 0; g < 3; g++) last_rx[g] = '0;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom);
      wait_clk(5); sclk = 1'b1;
      wait_clk(5); sclk = 1'b0;
    end
    check("busy_after_reset", busy[0], 0);
    check("miso_en_after_reset", miso_en[0], 0);
    check("tx_ready_after_reset", tx_ready[0], 1);
    check("rx_data_after_reset", rx_data[0], 0);
    cs_n[0] = 1'b1;
    wait_clk(6);
    m_words[0] = 8'h66; t_words[0] = 8'h99;
    run_frame(0, 1, 1, 0);

    m_words[0] = 8'h80; t_words[0] = 8'h01;
    run_frame(2, 1, 1, 0);

    for (int r = 0; r < 24; r++) begin
      int rg, rn, rt;
      rg = $urandom_range(0, 2);
      rn = $urandom_range(1, 3);
      rt = $urandom_range(0, rn);
      for (int k = 0; k < 4; k++) begin
        m_words[k] = 8'($urandom);
        t_words[k] = 8'($urandom);
      end
      run_frame(rg, rn, rt, 0);
    end

    wait_clk(4);
    check("rx_queue_empty", exp_rx.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
